sm4_ctrl: RTL and testbench



---
 rtl/sm4_pkg.sv | 31 +++
 rtl/sm4_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_sm4_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 request sequencer.
package sm4_pkg;

  localparam int unsigned SM4_BLK_W         = 128;
  localparam int unsigned SM4_RK_W          = 32;
  localparam int unsigned SM4_CNT_W         = 7;
  localparam int unsigned SM4_KEXP_CYCLES   = 36;
  localparam int unsigned SM4_CRYPT_TIMEOUT = 64;

  localparam logic SM4_ENC = 1'b0;
  localparam logic SM4_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_CRYPT = 2'd2,
    ST_OUT   = 2'd3
  } sm4_state_e;

  // Hit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm4_ctrl.sv
// SM4 request sequencer: accepts one request, re-expands the key schedule only
// when the cached key/direction does not match, runs the round engine with a
// timeout, and holds the result until the host takes it.
module sm4_ctrl
  import sm4_pkg::*;
#(
  parameter int unsigned KEXP_CYCLES   = SM4_KEXP_CYCLES,
  parameter int unsigned CRYPT_TIMEOUT = SM4_CRYPT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SM4_BLK_W-1:0] in_key,
  input  logic [SM4_BLK_W-1:0] in_data,
  input  logic                 in_enc_dec,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SM4_BLK_W-1:0] out_data,
  output logic                 out_err,
  output logic                 busy,
  output logic [15:0]          hit_cnt,
  output logic                 kexp_sm4_enable,
  output logic                 kexp_enable,
  output logic                 kexp_enc_dec,
  output logic [SM4_BLK_W-1:0] kexp_key,
  output logic                 rnd_start,
  output logic [SM4_BLK_W-1:0] rnd_data,
  input  logic                 rnd_done,
  input  logic [SM4_BLK_W-1:0] rnd_result
);

  localparam logic [SM4_CNT_W-1:0] KEXP_LAST  = SM4_CNT_W'(KEXP_CYCLES - 32'd1);
  localparam logic [SM4_CNT_W-1:0] CRYPT_LAST = SM4_CNT_W'(CRYPT_TIMEOUT - 32'd1);

  sm4_state_e           r_state;
  sm4_state_e           w_state_nxt;
  logic [SM4_CNT_W-1:0] r_cnt;

  logic [SM4_BLK_W-1:0] r_req_key;
  logic [SM4_BLK_W-1:0] r_req_data;
  logic                 r_req_dir;

  logic [SM4_BLK_W-1:0] r_cache_key;
  logic                 r_cache_dir;
  logic                 r_cache_vld;
  logic                 r_flush_seen;

  logic [15:0]          r_hit_cnt;
  logic [SM4_BLK_W-1:0] r_out_data;
  logic                 r_out_err;

  logic                 w_accept;
  logic                 w_hit;
  logic                 w_kexp_last;
  logic                 w_crypt_last;

  // The hit check looks at the incoming request and the cache as it stands
  // before this edge, so a flush arriving with the request cannot cancel it.
  assign w_accept     = (r_state == ST_IDLE) & in_valid;
  assign w_hit        = r_cache_vld &
                        ({in_key, in_enc_dec} == {r_cache_key, r_cache_dir});
  assign w_kexp_last  = (r_state == ST_KEXP)  & (r_cnt == KEXP_LAST);
  assign w_crypt_last = (r_state == ST_CRYPT) & (r_cnt == CRYPT_LAST);

  // State register plus the shared phase counter, cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= 7'd0;
      end else if ((r_state == ST_KEXP) || (r_state == ST_CRYPT)) begin
        r_cnt <= r_cnt + 7'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_hit ? ST_CRYPT : ST_KEXP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KEXP: begin
        if (w_kexp_last) begin
          w_state_nxt = ST_CRYPT;
        end else begin
          w_state_nxt = ST_KEXP;
        end
      end
      ST_CRYPT: begin
        // A done pulse on the timeout cycle still counts as a normal result.
        if (rnd_done || w_crypt_last) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_CRYPT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control outputs decoded purely from the registered state and counter.
  always_comb begin
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    busy            = 1'b1;
    kexp_sm4_enable = 1'b0;
    kexp_enable     = 1'b0;
    rnd_start       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_KEXP: begin
        kexp_sm4_enable = 1'b1;
        kexp_enable     = (r_cnt == 7'd0);
      end
      ST_CRYPT: begin
        rnd_start = (r_cnt == 7'd0);
      end
      ST_OUT: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Request latch: captured once on accept and held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_key  <= 128'd0;
      r_req_data <= 128'd0;
      r_req_dir  <= 1'b0;
    end else if (w_accept) begin
      r_req_key  <= in_key;
      r_req_data <= in_data;
      r_req_dir  <= in_enc_dec;
    end else begin
      r_req_key  <= r_req_key;
      r_req_data <= r_req_data;
      r_req_dir  <= r_req_dir;
    end
  end

  // Key cache: flush always wins; a miss invalidates until expansion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_vld <= 1'b0;
    end else if (flush) begin
      r_cache_vld <= 1'b0;
    end else if (w_accept && !w_hit) begin
      r_cache_vld <= 1'b0;
    end else if (w_kexp_last) begin
      r_cache_vld <= ~r_flush_seen;
    end else begin
      r_cache_vld <= r_cache_vld;
    end
  end

  // Cached key/direction, refreshed when an expansion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_key <= 128'd0;
      r_cache_dir <= 1'b0;
    end else if (w_kexp_last) begin
      r_cache_key <= r_req_key;
      r_cache_dir <= r_req_dir;
    end else begin
      r_cache_key <= r_cache_key;
      r_cache_dir <= r_cache_dir;
    end
  end

  // Remembers a flush seen during the current expansion; rearmed on KEXP entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_seen <= 1'b0;
    end else if (w_accept && !w_hit) begin
      r_flush_seen <= 1'b0;
    end else if (flush) begin
      r_flush_seen <= 1'b1;
    end else begin
      r_flush_seen <= r_flush_seen;
    end
  end

  // Saturating count of requests served from the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= 16'd0;
    end else if (w_accept && w_hit) begin
      r_hit_cnt <= sat_inc16(r_hit_cnt);
    end else begin
      r_hit_cnt <= r_hit_cnt;
    end
  end

  // Result register: written only when CRYPT finishes, then held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= 128'd0;
      r_out_err  <= 1'b0;
    end else if ((r_state == ST_CRYPT) && rnd_done) begin
      r_out_data <= rnd_result;
      r_out_err  <= 1'b0;
    end else if (w_crypt_last) begin
      r_out_data <= 128'd0;
      r_out_err  <= 1'b1;
    end else begin
      r_out_data <= r_out_data;
      r_out_err  <= r_out_err;
    end
  end

  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign hit_cnt      = r_hit_cnt;
  assign kexp_key     = r_req_key;
  assign kexp_enc_dec = r_req_dir;
  assign rnd_data     = r_req_data;

endmodule

// File: tb/tb_sm4_ctrl.sv
// Directed bench for sm4_ctrl with a behavioural round engine.
module tb_sm4_ctrl;

  localparam int KEXP    = 36;
  localparam int TO      = 64;
  localparam int ENG_LAT = 5;
  localparam int NV      = 10;

  localparam logic [127:0] K1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3 = 128'hcafef00dcafef00dcafef00dcafef00d;
  localparam logic [127:0] V0 = 128'h681edf34d206965e86b3e94f536e4246;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic         dir;
    int           fl_mode;   // 0 none, 1 flush at KEXP cycle 10, 2 flush with accept
    logic         eng_on;
    logic [127:0] eng_val;
    logic         exp_hit;
    logic [15:0]  exp_hcnt;
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         in_enc_dec;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;
  logic [15:0]  hit_cnt;
  logic         kexp_sm4_enable;
  logic         kexp_enable;
  logic         kexp_enc_dec;
  logic [127:0] kexp_key;
  logic         rnd_start;
  logic [127:0] rnd_data;
  logic         rnd_done;
  logic [127:0] rnd_result;

  int n_cmp = 0;
  int n_bad = 0;

  logic         eng_on  = 1'b0;
  logic [127:0] eng_val = 128'd0;
  int           eng_cnt = 0;

  vec_t vec [NV];

  always #5 clk = ~clk;

  sm4_ctrl #(.KEXP_CYCLES(KEXP), .CRYPT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .in_enc_dec(in_enc_dec), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .hit_cnt(hit_cnt),
    .kexp_sm4_enable(kexp_sm4_enable), .kexp_enable(kexp_enable),
    .kexp_enc_dec(kexp_enc_dec), .kexp_key(kexp_key),
    .rnd_start(rnd_start), .rnd_data(rnd_data),
    .rnd_done(rnd_done), .rnd_result(rnd_result)
  );

  // Round engine model: pulses done ENG_LAT negedges after seeing rnd_start.
  always @(negedge clk) begin
    if (rnd_start === 1'b1 && eng_on) eng_cnt = ENG_LAT;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        rnd_done   = 1'b1;
        rnd_result = eng_val;
      end else begin
        rnd_done   = 1'b0;
        rnd_result = ~eng_val;
      end
    end else begin
      rnd_done   = 1'b0;
      rnd_result = {4{32'hdeadbeef}};
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic wait_ov(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: out_valid not seen within 200 cycles", nm);
    end
  endtask

  // One full transaction: accept, observe the sequencing, collect and ack the result.
  task automatic do_req(input logic [127:0] key, input logic [127:0] data, input logic dir,
                        input int fl_mode, output int n_kexp, output int start_dly,
                        output int lat, output logic [127:0] res, output logic err,
                        output logic dir_ok, output logic hold_ok);
    bit got;
    n_kexp = 0; start_dly = -1; lat = -1; res = 128'd0; err = 1'b0;
    dir_ok = 1'b1; hold_ok = 1'b1; got = 1'b0;
    for (int t = 0; t < 20 && in_ready !== 1'b1; t++) @(negedge clk);
    in_valid = 1'b1; in_key = key; in_data = data; in_enc_dec = dir;
    flush = (fl_mode == 2);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    in_key = ~key; in_data = ~data; in_enc_dec = ~dir;
    for (int t = 0; t < 200; t++) begin
      if (kexp_enable === 1'b1) begin
        n_kexp++;
        if (kexp_enc_dec !== dir) dir_ok = 1'b0;
      end
      if (kexp_sm4_enable === 1'b1 && kexp_key !== key) hold_ok = 1'b0;
      if (rnd_start === 1'b1 && start_dly < 0) begin
        start_dly = t;
        if (rnd_data !== data) hold_ok = 1'b0;
      end
      if (out_valid === 1'b1) begin
        got = 1'b1; lat = t; res = out_data; err = out_err;
        break;
      end
      flush = (fl_mode == 1 && t == 10);
      @(negedge clk);
    end
    flush = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL req wait: no result within 200 cycles");
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int n_kexp, start_dly, lat, exp_lat;
    logic [127:0] res;
    logic err, dir_ok, hold_ok;

    vec[0] = '{K1, K1,            1'b0, 0, 1'b1, V0,              1'b0, 16'd0, 1'b0, V0};
    vec[1] = '{K1, 128'h11,       1'b0, 0, 1'b1, 128'ha1a1,       1'b1, 16'd1, 1'b0, 128'ha1a1};
    vec[2] = '{K1, 128'h22,       1'b1, 0, 1'b1, 128'hb2b2,       1'b0, 16'd1, 1'b0, 128'hb2b2};
    vec[3] = '{K1, 128'h33,       1'b1, 0, 1'b1, 128'hc3c3,       1'b1, 16'd2, 1'b0, 128'hc3c3};
    vec[4] = '{K2, 128'h44,       1'b0, 1, 1'b1, 128'hd4d4,       1'b0, 16'd2, 1'b0, 128'hd4d4};
    vec[5] = '{K2, 128'h55,       1'b0, 0, 1'b1, 128'he5e5,       1'b0, 16'd2, 1'b0, 128'he5e5};
    vec[6] = '{K2, 128'h66,       1'b0, 2, 1'b1, 128'hf6f6,       1'b1, 16'd3, 1'b0, 128'hf6f6};
    vec[7] = '{K2, 128'h77,       1'b0, 0, 1'b1, 128'h0707,       1'b0, 16'd3, 1'b0, 128'h0707};
    vec[8] = '{K2, 128'h88,       1'b0, 0, 1'b0, 128'h1818,       1'b1, 16'd4, 1'b1, 128'd0};
    vec[9] = '{K2, 128'h99,       1'b0, 0, 1'b1, 128'h2929,       1'b1, 16'd5, 1'b0, 128'h2929};

    rst_n = 1'b0; in_valid = 1'b0; in_key = 128'd0; in_data = 128'd0;
    in_enc_dec = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready",  128'(in_ready),  128'd1);
    chk("rst busy",      128'(busy),      128'd0);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst hit_cnt",   128'(hit_cnt),   128'd0);
    chk("rst out_data",  out_data,        128'd0);
    chk("rst out_err",   128'(out_err),   128'd0);
    chk("rst kexp_en",   128'({kexp_enable, kexp_sm4_enable, rnd_start}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      eng_on  = vec[i].eng_on;
      eng_val = vec[i].eng_val;
      do_req(vec[i].key, vec[i].data, vec[i].dir, vec[i].fl_mode,
             n_kexp, start_dly, lat, res, err, dir_ok, hold_ok);
      exp_lat = (vec[i].exp_hit ? 0 : KEXP) + (vec[i].eng_on ? ENG_LAT : TO);
      chk($sformatf("v%0d start_dly", i), 128'(start_dly), 128'(vec[i].exp_hit ? 0 : KEXP));
      chk($sformatf("v%0d kexp_pulses", i), 128'(n_kexp), 128'(vec[i].exp_hit ? 0 : 1));
      chk($sformatf("v%0d latency", i), 128'(lat), 128'(exp_lat));
      chk($sformatf("v%0d out_data", i), res, vec[i].exp_data);
      chk($sformatf("v%0d out_err", i), 128'(err), 128'(vec[i].exp_err));
      chk($sformatf("v%0d hit_cnt", i), 128'(hit_cnt), 128'(vec[i].exp_hcnt));
      chk($sformatf("v%0d in_ready_after_ack", i), 128'(in_ready), 128'd1);
      chk($sformatf("v%0d kexp_dir", i), 128'(dir_ok), 128'd1);
      chk($sformatf("v%0d req_hold", i), 128'(hold_ok), 128'd1);
    end

    // Backpressure: result must stay put while the host stalls with a request pending.
    eng_on = 1'b1; eng_val = 128'h5a5a_0000_1234;
    in_valid = 1'b1; in_key = K2; in_data = 128'haa; in_enc_dec = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov("bp first");
    eng_val = 128'h77aa;
    in_valid = 1'b1; in_key = K1; in_data = 128'hbb; in_enc_dec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d in_ready", i), 128'(in_ready), 128'd0);
      chk($sformatf("bp%0d out_data", i), out_data, 128'h5a5a_0000_1234);
    end
    chk("bp hit_cnt", 128'(hit_cnt), 128'd6);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp in_ready after ack", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next accepted busy", 128'(busy), 128'd1);
    chk("bp next miss kexp", 128'(kexp_enable), 128'd1);
    wait_ov("bp second");
    chk("bp second data", out_data, 128'h77aa);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a key expansion abandons everything.
    in_valid = 1'b1; in_key = K3; in_data = 128'hcc; in_enc_dec = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid kexp enable", 128'(kexp_sm4_enable), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 128'(busy), 128'd0);
    chk("async rst kexp_sm4_enable", 128'(kexp_sm4_enable), 128'd0);
    chk("async rst out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", 128'(in_ready), 128'd1);
    chk("post rst hit_cnt", 128'(hit_cnt), 128'd0);
    eng_on = 1'b1; eng_val = V0;
    do_req(K1, K1, 1'b0, 0, n_kexp, start_dly, lat, res, err, dir_ok, hold_ok);
    chk("post rst miss kexp", 128'(n_kexp), 128'd1);
    chk("post rst start_dly", 128'(start_dly), 128'(KEXP));
    chk("post rst out_data", res, V0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
